// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame-buffer arbiter (display read > clear write > draw-FIFO drain)
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   disp_req/disp_addr     display fetch request, served combinationally
//   disp_rdata/disp_rvalid fetched pixel, valid one cycle after the fetch
//   draw_valid/draw_ready  draw-write handshake into a FIFO_DEPTH-entry FIFO
//   draw_addr/draw_data    draw-write address and pixel
//   clr_start/clr_color    start a FB_WORDS-word clear with the given pixel
//   clr_busy/clr_done      clear in progress / one-cycle completion pulse
//   mem_*                  single-port RAM (1-cycle read latency)
//   stall_cnt              display-stall counter, present only with FB_ARBITER_STATS_EN
module fb_arbiter #(
  parameter int AW         = 19,
  parameter int DW         = 8,
  parameter int FB_WORDS   = 307200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_rdata,
  output logic          disp_rvalid,
  input  logic          draw_valid,
  output logic          draw_ready,
  input  logic [AW-1:0] draw_addr,
  input  logic [DW-1:0] draw_data,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef FB_ARBITER_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(FB_WORDS - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PMAX = PW'(FIFO_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;
  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [DW-1:0] color_q;
  logic          rvalid_q;
  logic [AW-1:0] f_addr [FIFO_DEPTH];
  logic [DW-1:0] f_data [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, clr_wr;
  // full/empty come from the registered count only, so a same-cycle pop
  // never frees a slot for a push and a same-cycle push is never popped
  assign draw_ready  = cnt_q != FULL;
  assign push        = draw_valid && draw_ready;
  assign clr_wr      = state_q == CLEAR && !disp_req;
  assign pop         = cnt_q != '0 && !disp_req && state_q != CLEAR;
  assign cnt_d       = cnt_q + CW'(push) - CW'(pop);
  assign disp_rvalid = rvalid_q;
  assign disp_rdata  = mem_rdata;
  assign clr_busy    = state_q == CLEAR;
  assign clr_done    = state_q == DONE;
  always_comb begin
    mem_en    = disp_req || clr_wr || pop;
    mem_we    = clr_wr || pop;
    mem_addr  = disp_req ? disp_addr : clr_wr ? ptr_q : pop ? f_addr[rd_q] : '0;
    mem_wdata = disp_req ? '0 : clr_wr ? color_q : pop ? f_data[rd_q] : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      color_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= disp_req;
      unique case (state_q)
        IDLE: if (clr_start) begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          color_q <= clr_color;
        end
        CLEAR: if (!disp_req) begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LAST) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q == PMAX ? '0 : wr_q + 1'b1;
      if (pop) rd_q <= rd_q == PMAX ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
  // FIFO storage needs no reset: entries are only read below the count
  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wr_q] <= draw_addr;
      f_data[wr_q] <= draw_data;
    end
  end
`ifdef FB_ARBITER_STATS_EN
  logic [15:0] stall_q;
  assign stall_cnt = stall_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else if (disp_req && (cnt_q != '0 || state_q == CLEAR) && stall_q != 16'hFFFF)
      stall_q <= stall_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed and randomized checks of fb_arbiter against a queue-based model
module tb_fb_arbiter;
  localparam int AW = 8, DW = 8, FBW = 16, FD = 4;
  logic clk = 0, rst = 0;
  logic disp_req = 0, draw_valid = 0, clr_start = 0;
  logic [AW-1:0] disp_addr = 0, draw_addr = 0;
  logic [DW-1:0] draw_data = 0, clr_color = 0;
  logic [DW-1:0] disp_rdata, mem_wdata, mem_rdata;
  logic disp_rvalid, draw_ready, clr_busy, clr_done, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
`ifdef FB_ARBITER_STATS_EN
  logic [15:0] stall_cnt;
`endif
  always #5 clk = ~clk;
  fb_arbiter #(.AW(AW), .DW(DW), .FB_WORDS(FBW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid), .draw_valid(draw_valid),
    .draw_ready(draw_ready), .draw_addr(draw_addr), .draw_data(draw_data),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .clr_done(clr_done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef FB_ARBITER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  logic [DW-1:0] ram [256];
  logic [DW-1:0] emem [256];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  int checks = 0, errors = 0, cyc = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  logic [AW+DW-1:0] q [$];
  logic [AW+DW-1:0] h;
  bit mc, md, mrv, er, ecw, ep, epush, md_old;
  int mp, mstall, sz;
  logic [DW-1:0] mcol, mrexp;
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;
  logic [AW-1:0] wl_addr [$];
  logic [DW-1:0] wl_data [$];
  int wl_cyc [$];
  int busy_n = 0, done_n = 0, done_cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      q.delete();
      mc = 0; md = 0; mrv = 0; mp = 0; mstall = 0;
    end
    er  = disp_req;
    ecw = mc && !disp_req;
    ep  = !er && !mc && q.size() > 0;
    h   = q.size() > 0 ? q[0] : '0;
    ea  = er ? disp_addr : ecw ? AW'(mp) : ep ? h[AW+DW-1:DW] : '0;
    ed  = er ? '0 : ecw ? mcol : ep ? h[DW-1:0] : '0;
    chk("mem_en", mem_en, er || ecw || ep);
    chk("mem_we", mem_we, ecw || ep);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("draw_ready", draw_ready, q.size() < FD);
    chk("clr_busy", clr_busy, mc);
    chk("clr_done", clr_done, md);
    chk("disp_rvalid", disp_rvalid, mrv);
    if (mrv) chk("disp_rdata", disp_rdata, mrexp);
`ifdef FB_ARBITER_STATS_EN
    chk("stall_cnt", stall_cnt, mstall);
`endif
    if (rst) begin
      if (mem_en && mem_we) begin
        wl_addr.push_back(mem_addr); wl_data.push_back(mem_wdata); wl_cyc.push_back(cyc);
      end
      if (clr_busy) busy_n++;
      if (clr_done) begin done_n++; done_cyc = cyc; end
      sz = q.size();
      epush = draw_valid && sz < FD;
      md_old = md;
      if (disp_req) mrexp = emem[disp_addr];
      if (ep) begin emem[h[AW+DW-1:DW]] = h[DW-1:0]; void'(q.pop_front()); end
      if (epush) q.push_back({draw_addr, draw_data});
      if (disp_req && (sz > 0 || mc) && mstall < 65535) mstall++;
      md = 0;
      if (ecw) begin
        emem[mp] = mcol;
        if (mp == FBW - 1) begin mc = 0; md = 1; end
        else mp++;
      end else if (!mc && !md_old && clr_start) begin
        mc = 1; mp = 0; mcol = clr_color;
      end
      mrv = disp_req;
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic clear_log();
    wl_addr.delete(); wl_data.delete(); wl_cyc.delete();
  endtask
  int n, bad;
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] <= 8'(i * 7 + 3);
      emem[i] = 8'(i * 7 + 3);
    end
    ram[16] <= 8'h5A;
    emem[16] = 8'h5A;
    @(negedge clk);
    chk("reset_draw_ready", draw_ready, 1);
    chk("reset_clr_busy", clr_busy, 0);
    chk("reset_rvalid", disp_rvalid, 0);
    tick(); rst = 1; tick();
    disp_req = 1; disp_addr = 8'h10;
    @(negedge clk);
    chk("rd_addr", mem_addr, 8'h10);
    chk("rd_we", mem_we, 0);
    tick(); disp_req = 0;
    @(negedge clk);
    chk("rd_valid", disp_rvalid, 1);
    chk("rd_data", disp_rdata, 8'h5A);
    tick();
    disp_req = 1;
    for (int i = 0; i < 4; i++) begin
      draw_valid = 1; draw_addr = 8'h40 + 8'(i); draw_data = 8'hA0 + 8'(i); tick();
    end
    draw_valid = 0;
    clear_log();
    @(negedge clk);
    chk("full_ready", draw_ready, 0);
    tick(); disp_req = 0;
    @(negedge clk); tick();
    @(negedge clk);
    chk("ready_after_pop", draw_ready, 1);
    repeat (5) tick();
    chk("drain_count", wl_addr.size(), 4);
    for (int i = 0; i < 4 && i < wl_addr.size(); i++) begin
      chk("drain_addr", wl_addr[i], 8'h40 + i);
      chk("drain_data", wl_data[i], 8'hA0 + i);
      chk("drain_consec", wl_cyc[i], wl_cyc[0] + i);
    end
    clear_log(); busy_n = 0; done_n = 0;
    clr_color = 8'h3C; clr_start = 1; tick(); clr_start = 0;
    draw_valid = 1; draw_addr = 8'h05; draw_data = 8'hFF; tick(); draw_valid = 0;
    for (int i = 0; i < 30; i++) begin
      disp_req = (i == 3 || i == 7 || i == 8); tick();
    end
    disp_req = 0;
    n = 0; bad = 0;
    for (int i = 0; i < wl_addr.size(); i++)
      if (wl_data[i] == 8'h3C) begin
        if (wl_addr[i] != 8'(n)) bad++;
        n++;
      end
    chk("clear_writes", n, 16);
    chk("clear_order_bad", bad, 0);
    chk("clear_busy_cycles", busy_n, 19);
    chk("clear_done_pulses", done_n, 1);
    n = -1;
    for (int i = 0; i < wl_addr.size(); i++)
      if (wl_addr[i] == 8'h05 && wl_data[i] == 8'hFF) n = wl_cyc[i];
    chk("draw_after_done", n >= done_cyc && done_n == 1, 1);
    @(negedge clk);
    chk("ram5", ram[5], 8'hFF);
    tick();
    clr_color = 8'h11; clr_start = 1; tick(); clr_start = 0;
    for (int i = 0; i < 7; i++) begin
      draw_valid = i < 2; draw_addr = 8'h80 + 8'(i); draw_data = 8'h99; tick();
    end
    draw_valid = 0;
    rst = 0; clear_log(); done_n = 0;
    tick(); rst = 1;
    repeat (10) tick();
    chk("abort_writes", wl_addr.size(), 0);
    chk("abort_done", done_n, 0);
    @(negedge clk);
    chk("abort_ready", draw_ready, 1);
    chk("abort_busy", clr_busy, 0);
    chk("abort_ram80", ram[8'h80], 8'(8'h80 * 7 + 3));
`ifdef FB_ARBITER_STATS_EN
    tick();
    disp_req = 1; draw_valid = 1; draw_addr = 8'h90; draw_data = 8'h77; tick();
    draw_valid = 0;
    repeat (10) tick();
    @(negedge clk);
    chk("stall_10", stall_cnt, 10);
    tick(); disp_req = 0;
    repeat (3) tick();
`endif
    for (int i = 0; i < 3000; i++) begin
      disp_req   = $urandom_range(0, 99) < 45;
      disp_addr  = 8'($urandom);
      draw_valid = $urandom_range(0, 1) == 1;
      draw_addr  = 8'($urandom);
      draw_data  = 8'($urandom);
      clr_start  = $urandom_range(0, 49) == 0;
      clr_color  = 8'($urandom);
      rst        = $urandom_range(0, 499) != 0;
      tick();
    end
    disp_req = 0; draw_valid = 0; clr_start = 0; rst = 1;
    repeat (40) tick();
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== emem[i]) bad++;
    chk("ram_image_mismatches", bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
